// File: rtl/block_sync_rx.sv
// Receive block-lock controller for the 64b/66b PCS: hunts for sync-header alignment
// by slipping the gearbox, holds lock while headers stay valid, forwards locked blocks.
module block_sync_rx #(
    parameter int HEAD_W         = 2,
    parameter int DATA_W         = 64,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              signal_v_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              slip_v_o,
    output logic              lock_v_o,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W = $clog2(SH_INVALID_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0] INV_END = INV_W'(SH_INVALID_MAX);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        UNLOCKED = 2'd1,
        LOCKED   = 2'd2,
        SLIP     = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] sh_cnt, sh_cnt_nxt, sh_cnt_inc;
    logic [INV_W-1:0] sh_inv_cnt, sh_inv_cnt_nxt, sh_inv_cnt_inc;
    logic             hdr_ok;
    logic             hdr_count;

    assign hdr_ok         = head_i[1] ^ head_i[0];
    // The header seen during a slip still has the old alignment, so it never counts.
    assign hdr_count      = valid_i && (state == UNLOCKED || state == LOCKED) && !slip_v_o;
    assign sh_cnt_inc     = sh_cnt + 1'b1;
    assign sh_inv_cnt_inc = sh_inv_cnt + {{(INV_W-1){1'b0}}, ~hdr_ok};

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= INIT;
            sh_cnt     <= '0;
            sh_inv_cnt <= '0;
        end else begin
            state      <= state_nxt;
            sh_cnt     <= sh_cnt_nxt;
            sh_inv_cnt <= sh_inv_cnt_nxt;
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        sh_cnt_nxt     = sh_cnt;
        sh_inv_cnt_nxt = sh_inv_cnt;
        if (!signal_v_i) begin
            state_nxt      = INIT;
            sh_cnt_nxt     = '0;
            sh_inv_cnt_nxt = '0;
        end else begin
            unique case (state)
                INIT: begin
                    state_nxt      = UNLOCKED;
                    sh_cnt_nxt     = '0;
                    sh_inv_cnt_nxt = '0;
                end
                UNLOCKED: begin
                    if (hdr_count) begin
                        if (!hdr_ok) begin
                            state_nxt  = SLIP;
                            sh_cnt_nxt = '0;
                        end else if (sh_cnt_inc == CNT_END) begin
                            state_nxt  = LOCKED;
                            sh_cnt_nxt = '0;
                        end else begin
                            sh_cnt_nxt = sh_cnt_inc;
                        end
                        sh_inv_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (hdr_count) begin
                        // Losing lock wins over a window that ends on the same header.
                        if (sh_inv_cnt_inc == INV_END) begin
                            state_nxt      = SLIP;
                            sh_cnt_nxt     = '0;
                            sh_inv_cnt_nxt = '0;
                        end else if (sh_cnt_inc == CNT_END) begin
                            sh_cnt_nxt     = '0;
                            sh_inv_cnt_nxt = '0;
                        end else begin
                            sh_cnt_nxt     = sh_cnt_inc;
                            sh_inv_cnt_nxt = sh_inv_cnt_inc;
                        end
                    end
                end
                SLIP: begin
                    state_nxt      = UNLOCKED;
                    sh_cnt_nxt     = '0;
                    sh_inv_cnt_nxt = '0;
                end
                default: begin
                    state_nxt      = INIT;
                    sh_cnt_nxt     = '0;
                    sh_inv_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        lock_v_o = (state == LOCKED);
        slip_v_o = (state == SLIP);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i & lock_v_o;
        end
    end

    // NOTE: payload flops carry no reset; they are qualified by valid_o downstream.
    always_ff @(posedge clk) begin
        head_o <= head_i;
        data_o <= data_i;
    end

endmodule

// File: tb/tb_block_sync_rx.sv
// Directed bench for block_sync_rx: a behavioural lock model checked every cycle,
// plus hand-computed expectations at the key acquisition, slip and loss-of-lock points.
module tb_block_sync_rx;

    logic        clk;
    logic        nreset;
    logic        signal_v_i;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        slip_v_o;
    logic        lock_v_o;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;

    int checks   = 0;
    int failures = 0;

    block_sync_rx dut (
        .clk        (clk),
        .nreset     (nreset),
        .signal_v_i (signal_v_i),
        .valid_i    (valid_i),
        .head_i     (head_i),
        .data_i     (data_i),
        .slip_v_o   (slip_v_o),
        .lock_v_o   (lock_v_o),
        .valid_o    (valid_o),
        .head_o     (head_o),
        .data_o     (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase of the lock procedure plus header/invalid tallies in the current window.
    localparam int P_WAIT   = 0;
    localparam int P_HUNT   = 1;
    localparam int P_LOCKED = 2;
    localparam int P_SLIP   = 3;

    int          m_phase = P_WAIT;
    int          m_hdrs  = 0;
    int          m_bad   = 0;
    logic        m_on    = 1'b0;
    logic        e_lock  = 1'b0;
    logic        e_slip  = 1'b0;
    logic        e_valid = 1'b0;
    logic [1:0]  e_head  = '0;
    logic [63:0] e_data  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic nr, input logic sv, input logic v,
                         input logic [1:0] h, input logic [63:0] d);
        logic good;
        good = (h == 2'b01) || (h == 2'b10);
        if (!nr) begin
            m_phase = P_WAIT;
            m_hdrs  = 0;
            m_bad   = 0;
            e_valid = 1'b0;
        end else begin
            e_valid = v && (m_phase == P_LOCKED);
            e_head  = h;
            e_data  = d;
            if (!sv) begin
                m_phase = P_WAIT;
                m_hdrs  = 0;
                m_bad   = 0;
            end else if (m_phase == P_WAIT || m_phase == P_SLIP) begin
                m_phase = P_HUNT;
                m_hdrs  = 0;
                m_bad   = 0;
            end else if (v) begin
                m_hdrs++;
                if (!good) m_bad++;
                if (m_phase == P_HUNT && m_bad > 0) begin
                    m_phase = P_SLIP;
                    m_hdrs  = 0;
                    m_bad   = 0;
                end else if (m_phase == P_LOCKED && m_bad == 16) begin
                    m_phase = P_SLIP;
                    m_hdrs  = 0;
                    m_bad   = 0;
                end else if (m_hdrs == 64) begin
                    m_phase = P_LOCKED;
                    m_hdrs  = 0;
                    m_bad   = 0;
                end
            end
        end
        e_lock = (m_phase == P_LOCKED);
        e_slip = (m_phase == P_SLIP);
    endtask

    task automatic cycle(input logic nr, input logic sv, input logic v, input logic [1:0] h);
        logic [63:0] d;
        d = {$urandom, $urandom};
        nreset     = nr;
        signal_v_i = sv;
        valid_i    = v;
        head_i     = h;
        data_i     = d;
        @(posedge clk);
        #1;
        model(nr, sv, v, h, d);
    endtask

    always @(negedge clk) begin
        if (m_on) begin
            check("lock_v_o", {63'b0, lock_v_o}, {63'b0, e_lock});
            check("slip_v_o", {63'b0, slip_v_o}, {63'b0, e_slip});
            check("valid_o", {63'b0, valid_o}, {63'b0, e_valid});
            if (e_valid) begin
                check("head_o", {62'b0, head_o}, {62'b0, e_head});
                check("data_o", data_o, e_data);
            end
        end
    end

    initial begin
        nreset     = 1'b0;
        signal_v_i = 1'b0;
        valid_i    = 1'b0;
        head_i     = 2'b01;
        data_i     = '0;

        cycle(0, 0, 0, 2'b01);
        cycle(0, 1, 1, 2'b01);
        m_on = 1'b1;
        check("reset_lock", {63'b0, lock_v_o}, 64'd0);
        check("reset_slip", {63'b0, slip_v_o}, 64'd0);
        check("reset_valid", {63'b0, valid_o}, 64'd0);

        // Unlocked: nine good headers, then a bad one forces a single slip.
        cycle(1, 1, 0, 2'b01);
        for (int i = 0; i < 9; i++) cycle(1, 1, 1, 2'b01);
        cycle(1, 1, 1, 2'b00);
        check("slip_after_bad", {63'b0, slip_v_o}, 64'd1);
        cycle(1, 1, 1, 2'b00);
        check("slip_one_cycle", {63'b0, slip_v_o}, 64'd0);
        check("unlocked_after_slip", {63'b0, lock_v_o}, 64'd0);

        // A full 64 further good headers are needed.
        for (int i = 0; i < 63; i++) cycle(1, 1, 1, 2'b01);
        check("no_lock_at_63", {63'b0, lock_v_o}, 64'd0);
        cycle(1, 1, 1, 2'b01);
        check("lock_at_64", {63'b0, lock_v_o}, 64'd1);
        cycle(1, 1, 1, 2'b10);
        check("fwd_valid_hi", {63'b0, valid_o}, 64'd1);
        cycle(1, 1, 0, 2'b10);
        check("fwd_valid_lo", {63'b0, valid_o}, 64'd0);

        // Locked window with 15 bad headers keeps lock (window was already 1 header in).
        for (int i = 0; i < 63; i++) cycle(1, 1, 1, (i % 4 == 0 && i < 60) ? 2'b11 : 2'b01);
        check("lock_held_15", {63'b0, lock_v_o}, 64'd1);

        // Next window: 16th bad header lands on header 61.
        for (int i = 0; i <= 60; i++) cycle(1, 1, 1, (i % 4 == 0) ? 2'b11 : 2'b01);
        check("lost_lock_16", {63'b0, lock_v_o}, 64'd0);
        check("slip_on_loss", {63'b0, slip_v_o}, 64'd1);
        cycle(1, 1, 1, 2'b01);
        for (int i = 0; i < 64; i++) cycle(1, 1, 1, 2'b01);
        check("relock", {63'b0, lock_v_o}, 64'd1);

        // 16th bad header is also the 64th of the window: loss of lock wins.
        for (int i = 0; i < 64; i++) cycle(1, 1, 1, (i % 4 == 3) ? 2'b11 : 2'b01);
        check("coincide_lock", {63'b0, lock_v_o}, 64'd0);
        check("coincide_slip", {63'b0, slip_v_o}, 64'd1);
        cycle(1, 1, 0, 2'b01);

        // Acquisition with valid_i on alternate cycles.
        for (int i = 0; i < 64; i++) begin
            cycle(1, 1, 1, 2'b01);
            if (i == 62) check("gap_no_lock_63", {63'b0, lock_v_o}, 64'd0);
            if (i == 63) check("gap_lock_64", {63'b0, lock_v_o}, 64'd1);
            cycle(1, 1, 0, 2'b01);
        end

        // One-cycle loss of PMA signal: lock drops without a slip, re-acquire from zero.
        cycle(1, 0, 1, 2'b01);
        check("sigloss_lock", {63'b0, lock_v_o}, 64'd0);
        check("sigloss_noslip", {63'b0, slip_v_o}, 64'd0);
        cycle(1, 1, 1, 2'b01);
        for (int i = 0; i < 63; i++) cycle(1, 1, 1, 2'b01);
        check("sig_relock_63", {63'b0, lock_v_o}, 64'd0);
        cycle(1, 1, 1, 2'b01);
        check("sig_relock_64", {63'b0, lock_v_o}, 64'd1);

        // Synchronous reset in the middle of a window.
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 2'b01);
        cycle(0, 1, 1, 2'b01);
        check("midreset_lock", {63'b0, lock_v_o}, 64'd0);
        check("midreset_slip", {63'b0, slip_v_o}, 64'd0);
        check("midreset_valid", {63'b0, valid_o}, 64'd0);
        cycle(1, 1, 0, 2'b01);
        cycle(1, 1, 0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
